// File: rtl/weight_stream_pkg.sv
// Shared types and constants for the weight stream source.
// Contents: FSM state encoding, default parameter values, skid depth.
// Latency / backpressure: n/a (declarations only).
package weight_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam int DEF_WEIGHT_WIDTH = 16;
  localparam int DEF_WEIGHT_SDIM  = 512;
  localparam int DEF_REPEAT_WIDTH = 16;

  // Entries held by the output skid buffer; read issue is credited against it.
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/weight_stream_skid.sv
// Two-entry AXI-Stream skid buffer; out_dat is always the head entry register.
// Latency: one cycle from in_vld to out_vld. Ports: in_vld/in_dat, out_vld/out_rdy/out_dat, count.
// Backpressure: no in_rdy; the producer must track count and never push into a full buffer.
module weight_stream_skid
  import weight_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WEIGHT_WIDTH + 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic [1:0]       cnt;
  logic             pop;

  assign out_vld = (cnt != 2'd0);
  assign out_dat = ent0;
  assign count   = cnt;
  assign pop     = out_vld & out_rdy;

  // ent0 only changes on a pop or while empty, which keeps the output
  // stable for the whole duration of a stall.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= in_dat;
          else             ent1 <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= in_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= in_dat;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/weight_stream_source.sv
// Streams a preloaded weight memory repeat_cnt times over AXI-Stream, tlast per pass.
// Latency: first beat two cycles after start; one beat per cycle under continuous ready.
// Backpressure: reads are credited against the skid buffer, so tready stalls never lose data.
// Ports: cfg_wr_* memory load (IDLE only), start/repeat_cnt, busy/done status, m_axis_weights_* stream.
module weight_stream_source
  import weight_stream_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int WEIGHT_SDIM  = DEF_WEIGHT_SDIM,
  parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(WEIGHT_SDIM)-1:0] cfg_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]        cfg_wr_data,
  input  logic                           start,
  input  logic [REPEAT_WIDTH-1:0]        repeat_cnt,
  output logic                           busy,
  output logic                           done,
  output logic [WEIGHT_WIDTH-1:0]        m_axis_weights_tdata,
  output logic                           m_axis_weights_tvalid,
  input  logic                           m_axis_weights_tready,
  output logic                           m_axis_weights_tlast
);

  localparam int AW = $clog2(WEIGHT_SDIM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WEIGHT_SDIM - 1);

  state_t                  state;
  logic [AW-1:0]           rd_addr;
  logic [REPEAT_WIDTH-1:0] pass_cnt;
  logic [REPEAT_WIDTH-1:0] rep_q;
  logic                    rd_vld_q;
  logic                    rd_last_q;
  logic [WEIGHT_WIDTH-1:0] rd_data;
  logic [WEIGHT_WIDTH-1:0] mem [WEIGHT_SDIM];

  logic [1:0]              skid_cnt;
  logic [WEIGHT_WIDTH:0]   skid_out;
  logic                    pop;
  logic [2:0]              occ;
  logic                    issue;
  logic [AW-1:0]           issue_addr;
  logic [REPEAT_WIDTH-1:0] pass_base;
  logic                    issue_wrap;
  logic                    final_read;
  logic                    wr_ok;

  assign pop   = m_axis_weights_tvalid & m_axis_weights_tready;
  assign wr_ok = cfg_wr_en & (state == ST_IDLE);
  assign busy  = (state != ST_IDLE);

  // Occupancy is measured after this cycle's departing beat, which is what
  // lets a steady one-beat-per-cycle stream keep a read in flight every cycle.
  assign occ = {1'b0, skid_cnt} + {2'b00, rd_vld_q} - {2'b00, pop};

  always_comb begin
    issue      = 1'b0;
    issue_addr = rd_addr;
    pass_base  = pass_cnt;
    final_read = 1'b0;
    case (state)
      ST_IDLE: begin
        // The start cycle itself issues address 0 so the first beat lands at start+2.
        issue      = start & (repeat_cnt != '0);
        issue_addr = '0;
        pass_base  = '0;
        final_read = issue & (issue_addr == LAST_ADDR) &
                     (repeat_cnt == REPEAT_WIDTH'(1));
      end
      ST_STREAM: begin
        issue      = (occ < 3'(SKID_DEPTH));
        final_read = issue & (issue_addr == LAST_ADDR) &
                     (pass_cnt == rep_q - REPEAT_WIDTH'(1));
      end
      default: begin
      end
    endcase
  end

  assign issue_wrap = (issue_addr == LAST_ADDR);

  // Simple dual-port RAM: write port plus registered read port, never reset.
  always_ff @(posedge ap_clk) begin
    if (wr_ok) mem[cfg_wr_addr] <= cfg_wr_data;
    if (issue) rd_data <= mem[issue_addr];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      pass_cnt  <= '0;
      rep_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      rd_vld_q  <= issue;
      rd_last_q <= issue & issue_wrap;
      if (issue) begin
        if (issue_wrap) begin
          rd_addr  <= '0;
          pass_cnt <= pass_base + REPEAT_WIDTH'(1);
        end else begin
          rd_addr  <= issue_addr + AW'(1);
          pass_cnt <= pass_base;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (repeat_cnt == '0) begin
              done <= 1'b1;
            end else begin
              rep_q <= repeat_cnt;
              state <= final_read ? ST_FLUSH : ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (final_read) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // All reads are out; the final beat is the last one left in the pipe.
          if (pop && skid_cnt == 2'd1 && !rd_vld_q) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  weight_stream_skid #(
    .WIDTH (WEIGHT_WIDTH + 1)
  ) u_skid (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_vld   (rd_vld_q),
    .in_dat   ({rd_last_q, rd_data}),
    .out_vld  (m_axis_weights_tvalid),
    .out_rdy  (m_axis_weights_tready),
    .out_dat  (skid_out),
    .count    (skid_cnt)
  );

  assign m_axis_weights_tdata = skid_out[WEIGHT_WIDTH-1:0];
  assign m_axis_weights_tlast = skid_out[WEIGHT_WIDTH];

endmodule

// File: tb/tb_weight_stream_source.sv
// Self-checking bench for weight_stream_source with a 4-word memory.
// A cycle table covers the back-to-back run, then a queue model checks the rest.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_weight_stream_source;

  localparam int WW = 16;
  localparam int SD = 4;
  localparam int RW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [1:0]    cfg_wr_addr = '0;
  logic [WW-1:0] cfg_wr_data = '0;
  logic          start = 1'b0;
  logic [RW-1:0] repeat_cnt = '0;
  logic          busy;
  logic          done;
  logic [WW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;

  always #5 ap_clk = ~ap_clk;

  weight_stream_source #(
    .WEIGHT_WIDTH (WW),
    .WEIGHT_SDIM  (SD),
    .REPEAT_WIDTH (RW)
  ) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .cfg_wr_en             (cfg_wr_en),
    .cfg_wr_addr           (cfg_wr_addr),
    .cfg_wr_data           (cfg_wr_data),
    .start                 (start),
    .repeat_cnt            (repeat_cnt),
    .busy                  (busy),
    .done                  (done),
    .m_axis_weights_tdata  (tdata),
    .m_axis_weights_tvalid (tvalid),
    .m_axis_weights_tready (tready),
    .m_axis_weights_tlast  (tlast)
  );

  int n_pass  = 0;
  int n_total = 0;
  int beats   = 0;

  // Reference model: memory image plus the queue of {tlast, tdata} still owed.
  logic [WW-1:0] mem_m [SD];
  logic [WW:0]   exp_q [$];
  logic          stall_prev = 1'b0;
  logic [WW:0]   held_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // One clock of the model: account for what the coming edge does, then compare.
  task automatic cycle();
    logic        mbusy;
    logic        nd;
    logic [WW:0] e;
    mbusy = (exp_q.size() != 0);
    nd    = 1'b0;
    if (tvalid && tready) begin
      beats++;
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_value", 32'({tlast, tdata}), 32'(e));
        if (exp_q.size() == 0) nd = 1'b1;
      end
    end
    if (start && !mbusy) begin
      if (repeat_cnt == 0) nd = 1'b1;
      else
        for (int p = 0; p < int'(repeat_cnt); p++)
          for (int a = 0; a < SD; a++)
            exp_q.push_back({(a == SD - 1), mem_m[a]});
    end
    if (cfg_wr_en && !mbusy) mem_m[cfg_wr_addr] = cfg_wr_data;
    stall_prev = tvalid && !tready;
    held_prev  = {tlast, tdata};
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("done", 32'(done), 32'(nd));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (stall_prev) begin
      check("stall_valid_held", 32'(tvalid), 32'd1);
      check("stall_data_held", 32'({tlast, tdata}), 32'(held_prev));
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [WW-1:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    cycle();
    cfg_wr_en = 1'b0;
  endtask

  task automatic kick(input logic [RW-1:0] r);
    start = 1'b1; repeat_cnt = r;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      cycle();
    end
    check("idle_reached", 32'(busy || exp_q.size() != 0), 32'd0);
  endtask

  typedef struct {
    logic          st;
    logic [RW-1:0] rep;
    logic          rdy;
    logic          busy;
    logic          done;
    logic          vld;
    logic          last;
    logic [WW-1:0] dat;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [RW-1:0] r, input logic b,
                              input logic dn, input logic v, input logic l,
                              input logic [WW-1:0] d);
    vec_t x;
    x.st = s; x.rep = r; x.rdy = 1'b1; x.busy = b; x.done = dn;
    x.vld = v; x.last = l; x.dat = d;
    return x;
  endfunction

  vec_t tbl [17];

  initial begin
    int b0;

    // Row i: inputs before edge i, outputs seen right after edge i.
    tbl[0]  = mk(1, 2, 1, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(0, 0, 1, 0, 1, 0, 16'h0011);
    tbl[2]  = mk(0, 0, 1, 0, 1, 0, 16'h0022);
    tbl[3]  = mk(0, 0, 1, 0, 1, 0, 16'h0033);
    tbl[4]  = mk(0, 0, 1, 0, 1, 1, 16'h0044);
    tbl[5]  = mk(0, 0, 1, 0, 1, 0, 16'h0011);
    tbl[6]  = mk(0, 0, 1, 0, 1, 0, 16'h0022);
    tbl[7]  = mk(0, 0, 1, 0, 1, 0, 16'h0033);
    tbl[8]  = mk(0, 0, 1, 0, 1, 1, 16'h0044);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 16'h0000);
    tbl[10] = mk(1, 1, 1, 0, 0, 0, 16'h0000);
    tbl[11] = mk(0, 0, 1, 0, 1, 0, 16'h0011);
    tbl[12] = mk(0, 0, 1, 0, 1, 0, 16'h0022);
    tbl[13] = mk(0, 0, 1, 0, 1, 0, 16'h0033);
    tbl[14] = mk(0, 0, 1, 0, 1, 1, 16'h0044);
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 16'h0000);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 16'h0000);

    for (int a = 0; a < SD; a++) mem_m[a] = '0;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    ap_rst_n = 1'b1;
    cycle();

    load(2'd0, 16'h0011);
    load(2'd1, 16'h0022);
    load(2'd2, 16'h0033);
    load(2'd3, 16'h0044);
    cycle();

    // Two back-to-back passes, then a restart in the done cycle.
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].st; repeat_cnt = tbl[i].rep; tready = tbl[i].rdy;
      @(posedge ap_clk);
      @(negedge ap_clk);
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      check($sformatf("tbl%0d_tvalid", i), 32'(tvalid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        check($sformatf("tbl%0d_tdata", i), 32'(tdata), 32'(tbl[i].dat));
        check($sformatf("tbl%0d_tlast", i), 32'(tlast), 32'(tbl[i].last));
      end
    end
    start = 1'b0;

    // Alternating ready: four ordered beats, held through every stall.
    b0 = beats;
    kick(16'd1);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tready = ~tready;
      cycle();
    end
    check("toggle_beats", 32'(beats - b0), 32'd4);
    tready = 1'b1;
    run_until_idle(10);

    // Zero repeat: done only, no beats, busy stays low.
    b0 = beats;
    kick(16'd0);
    cycle();
    cycle();
    check("zero_rep_beats", 32'(beats - b0), 32'd0);

    // Write during streaming is dropped; second pass still opens with 0x11.
    b0 = beats;
    kick(16'd2);
    cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = 16'hFFFF;
    cycle();
    cfg_wr_en = 1'b0;
    run_until_idle(40);
    check("drop_wr_beats", 32'(beats - b0), 32'd8);

    // Reset after the second beat of a pass.
    b0 = beats;
    kick(16'd1);
    for (int i = 0; i < 20; i++) begin
      if (beats - b0 >= 2) break;
      cycle();
    end
    check("rst_mid_reached", 32'(beats - b0), 32'd2);
    ap_rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", 32'(tvalid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_tvalid_hold", 32'(tvalid), 32'd0);
    end
    ap_rst_n = 1'b1;
    cycle();
    cycle();
    b0 = beats;
    kick(16'd1);
    run_until_idle(20);
    check("post_rst_beats", 32'(beats - b0), 32'd4);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tready = ($urandom_range(0, 9) < 7);
      start = 1'b0;
      cfg_wr_en = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        start = 1'b1;
        repeat_cnt = RW'($urandom_range(0, 3));
      end else if ($urandom_range(0, 7) == 0) begin
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 2'($urandom_range(0, 3));
        cfg_wr_data = WW'($urandom);
      end
      cycle();
    end
    start = 1'b0;
    cfg_wr_en = 1'b0;
    tready = 1'b1;
    run_until_idle(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
